// File: rtl/match_ctrl_if.sv
// Bundle between the Pong match sequencer and the rest of the game: frame strobe, button,
// paddle events and scores in; sequencing, ball control and score-counter pulses out.
interface match_ctrl_if #(
    parameter int unsigned SCORE_W = 4
);
    logic               tick;
    logic               start_btn;
    logic               hit_left;
    logic               hit_right;
    logic               miss_left;
    logic               miss_right;
    logic [SCORE_W-1:0] score_left;
    logic [SCORE_W-1:0] score_right;

    logic [2:0]         state;
    logic               ball_enable;
    logic               ball_reset;
    logic               serve_dir;
    logic               point_left;
    logic               point_right;
    logic               score_clear;
    logic [7:0]         rally_hits;
    logic [1:0]         speed_level;
    logic               game_over;
    logic               winner;

    modport master (
        output tick, start_btn, hit_left, hit_right, miss_left, miss_right,
               score_left, score_right,
        input  state, ball_enable, ball_reset, serve_dir, point_left, point_right,
               score_clear, rally_hits, speed_level, game_over, winner
    );

    modport slave (
        input  tick, start_btn, hit_left, hit_right, miss_left, miss_right,
               score_left, score_right,
        output state, ball_enable, ball_reset, serve_dir, point_left, point_right,
               score_clear, rally_hits, speed_level, game_over, winner
    );
endinterface

// File: rtl/match_ctrl.sv
// Pong match sequencer: serve / rally / point / game-over flow with registered outputs.
// Define MATCH_AUTO_RESTART_EN to let GAME_OVER fall back to IDLE after GAMEOVER_HOLD ticks.
module match_ctrl #(
    parameter int unsigned SCORE_W        = 4,
    parameter int unsigned WIN_SCORE      = 10,
    parameter int unsigned SERVE_DELAY    = 60,
    parameter int unsigned POINT_HOLD     = 90,
    parameter int unsigned HITS_PER_LEVEL = 4,
    parameter int unsigned GAMEOVER_HOLD  = 180
) (
    input logic        clk,
    input logic        reset,
    match_ctrl_if.slave ctrl
);

    localparam int unsigned MaxSp    = (SERVE_DELAY > POINT_HOLD) ? SERVE_DELAY : POINT_HOLD;
    localparam int unsigned MaxDelay = (MaxSp > GAMEOVER_HOLD) ? MaxSp : GAMEOVER_HOLD;
    localparam int unsigned CntW     = (MaxDelay > 0) ? $clog2(MaxDelay + 1) : 1;
    localparam int unsigned LvlW     = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StServeWait = 3'd1,
        StRally     = 3'd2,
        StPointHold = 3'd3,
        StGameOver  = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [LvlW-1:0]   lvl_cnt_q, lvl_cnt_d;
    logic              start_prev_q;
    logic              serve_dir_q, serve_dir_d;
    logic              point_left_q, point_left_d;
    logic              point_right_q, point_right_d;
    logic              score_clear_q, score_clear_d;
    logic [7:0]        rally_hits_q, rally_hits_d;
    logic [1:0]        speed_level_q, speed_level_d;
    logic              winner_q, winner_d;
    logic              ball_enable_q, ball_reset_q, game_over_q;

    logic              start_edge;
    logic              cnt_zero;
    logic              left_won, right_won;

    assign start_edge = ctrl.start_btn & ~start_prev_q;
    assign cnt_zero   = (cnt_q == '0);
    assign left_won   = {{(32 - SCORE_W){1'b0}}, ctrl.score_left} >= WIN_SCORE;
    assign right_won  = {{(32 - SCORE_W){1'b0}}, ctrl.score_right} >= WIN_SCORE;

    always_comb begin
        state_d       = state_q;
        serve_dir_d   = serve_dir_q;
        point_left_d  = 1'b0;
        point_right_d = 1'b0;
        score_clear_d = 1'b0;
        rally_hits_d  = rally_hits_q;
        speed_level_d = speed_level_q;
        lvl_cnt_d     = lvl_cnt_q;
        winner_d      = winner_q;

        unique case (state_q)
            StIdle: begin
                if (start_edge) begin
                    state_d       = StServeWait;
                    score_clear_d = 1'b1;
                    serve_dir_d   = 1'b1;
                end
            end
            StServeWait: begin
                if (cnt_zero) begin
                    state_d       = StRally;
                    rally_hits_d  = '0;
                    speed_level_d = '0;
                    lvl_cnt_d     = '0;
                end
            end
            StRally: begin
                // A miss ends the rally and swallows any hit in the same cycle.
                if (ctrl.miss_left || ctrl.miss_right) begin
                    state_d = StPointHold;
                    if (ctrl.miss_left && ctrl.miss_right) begin
                        serve_dir_d = ~serve_dir_q;
                    end else if (ctrl.miss_left) begin
                        point_right_d = 1'b1;
                        serve_dir_d   = 1'b0;
                    end else begin
                        point_left_d = 1'b1;
                        serve_dir_d  = 1'b1;
                    end
                end else if ((ctrl.hit_left || ctrl.hit_right) && (rally_hits_q != 8'hff)) begin
                    rally_hits_d = rally_hits_q + 8'd1;
                    if (lvl_cnt_q == LvlW'(HITS_PER_LEVEL - 1)) begin
                        lvl_cnt_d = '0;
                        if (speed_level_q != 2'd3) speed_level_d = speed_level_q + 2'd1;
                    end else begin
                        lvl_cnt_d = lvl_cnt_q + LvlW'(1);
                    end
                end
            end
            StPointHold: begin
                if (cnt_zero) begin
                    if (left_won) begin
                        state_d  = StGameOver;
                        winner_d = 1'b0;
                    end else if (right_won) begin
                        state_d  = StGameOver;
                        winner_d = 1'b1;
                    end else begin
                        state_d = StServeWait;
                    end
                end
            end
            StGameOver: begin
                if (start_edge) begin
                    state_d       = StServeWait;
                    score_clear_d = 1'b1;
                    serve_dir_d   = 1'b1;
                end
`ifdef MATCH_AUTO_RESTART_EN
                else if (cnt_zero) begin
                    state_d       = StIdle;
                    score_clear_d = 1'b1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase

        // Delay counter reloads on every state change, otherwise counts ticks down to zero.
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            case (state_d)
                StServeWait: cnt_d = CntW'(SERVE_DELAY);
                StPointHold: cnt_d = CntW'(POINT_HOLD);
                StGameOver:  cnt_d = CntW'(GAMEOVER_HOLD);
                default:     cnt_d = '0;
            endcase
        end else if (ctrl.tick && !cnt_zero) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            lvl_cnt_q     <= '0;
            start_prev_q  <= 1'b0;
            serve_dir_q   <= 1'b1;
            point_left_q  <= 1'b0;
            point_right_q <= 1'b0;
            score_clear_q <= 1'b0;
            rally_hits_q  <= '0;
            speed_level_q <= '0;
            winner_q      <= 1'b0;
            ball_enable_q <= 1'b0;
            ball_reset_q  <= 1'b1;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            lvl_cnt_q     <= lvl_cnt_d;
            start_prev_q  <= ctrl.start_btn;
            serve_dir_q   <= serve_dir_d;
            point_left_q  <= point_left_d;
            point_right_q <= point_right_d;
            score_clear_q <= score_clear_d;
            rally_hits_q  <= rally_hits_d;
            speed_level_q <= speed_level_d;
            winner_q      <= winner_d;
            ball_enable_q <= (state_d == StRally);
            ball_reset_q  <= (state_d != StRally);
            game_over_q   <= (state_d == StGameOver);
        end
    end

    assign ctrl.state       = state_q;
    assign ctrl.ball_enable = ball_enable_q;
    assign ctrl.ball_reset  = ball_reset_q;
    assign ctrl.serve_dir   = serve_dir_q;
    assign ctrl.point_left  = point_left_q;
    assign ctrl.point_right = point_right_q;
    assign ctrl.score_clear = score_clear_q;
    assign ctrl.rally_hits  = rally_hits_q;
    assign ctrl.speed_level = speed_level_q;
    assign ctrl.game_over   = game_over_q;
    assign ctrl.winner      = winner_q;

endmodule

// File: tb/tb_match_ctrl.sv
// Bench for match_ctrl: directed match walk-through plus random play, scored against a
// behavioural match model through an expected-event queue.
module tb_match_ctrl;

    localparam int unsigned SW  = 4;
    localparam int unsigned WIN = 3;
    localparam int unsigned SD  = 2;
    localparam int unsigned PH  = 2;
    localparam int unsigned HPL = 2;
    localparam int unsigned GH  = 5;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    match_ctrl_if #(.SCORE_W(SW)) bus ();

    match_ctrl #(
        .SCORE_W(SW), .WIN_SCORE(WIN), .SERVE_DELAY(SD), .POINT_HOLD(PH),
        .HITS_PER_LEVEL(HPL), .GAMEOVER_HOLD(GH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .ctrl (bus)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       en, rs, dir, pl, pr, sc;
        logic [7:0] hits;
        logic [1:0] lvl;
        logic       go, win;
    } snap_t;

    typedef struct {
        int    stamp;
        snap_t s;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Match model: mode 0 idle, 1 serve wait, 2 rally, 3 point hold, 4 game over.
    int    m_mode = 0, m_ticks = 0, m_hits = 0, m_lvl = 0;
    bit    m_dir = 1'b1, m_win = 1'b0, m_prev_start = 1'b0;
    int    sl_v = 0, sr_v = 0;
    bit    start_lvl = 1'b0;
    snap_t m_prev;

    function automatic snap_t mask(snap_t s);
        snap_t r = s;
        if (!r.go) r.win = 1'b0;
        return r;
    endfunction

    function automatic snap_t reset_snap();
        snap_t s = '0;
        s.rs  = 1'b1;
        s.dir = 1'b1;
        return s;
    endfunction

    function automatic snap_t dut_snap();
        snap_t s;
        s.st = bus.state;        s.en = bus.ball_enable; s.rs = bus.ball_reset;
        s.dir = bus.serve_dir;   s.pl = bus.point_left;  s.pr = bus.point_right;
        s.sc = bus.score_clear;  s.hits = bus.rally_hits; s.lvl = bus.speed_level;
        s.go = bus.game_over;    s.win = bus.winner;
        return mask(s);
    endfunction

    function automatic int hold_of(int mode);
        case (mode)
            1:       return SD;
            3:       return PH;
            4:       return GH;
            default: return 0;
        endcase
    endfunction

    task automatic enter(int mode);
        m_mode  = mode;
        m_ticks = 0;
    endtask

    // Advance the model across one clock edge and queue the resulting visible change.
    task automatic model_step(bit r, bit st, bit hl, bit hr, bit ml, bit mr, bit tk);
        bit    pl = 0, pr = 0, sc = 0;
        bit    edge_s = st && !m_prev_start;
        bit    expired = (m_ticks == hold_of(m_mode));
        snap_t s;
        exp_t  e;
        if (r) begin
            enter(0);
            m_hits = 0; m_lvl = 0; m_dir = 1'b1; m_win = 1'b0;
            m_prev_start = 1'b0;
            sl_v = 0; sr_v = 0;
        end else begin
            m_prev_start = st;
            case (m_mode)
                0: if (edge_s) begin sc = 1; m_dir = 1'b1; enter(1); end
                1: if (expired) begin m_hits = 0; m_lvl = 0; enter(2); end
                   else if (tk) m_ticks++;
                2: begin
                    if (ml && mr) begin m_dir = !m_dir; enter(3); end
                    else if (ml) begin pr = 1; m_dir = 1'b0; enter(3); end
                    else if (mr) begin pl = 1; m_dir = 1'b1; enter(3); end
                    else if ((hl || hr) && m_hits < 255) begin
                        m_hits++;
                        if (m_hits % HPL == 0 && m_lvl < 3) m_lvl++;
                    end
                end
                3: if (expired) begin
                       if (sl_v >= WIN)      begin m_win = 1'b0; enter(4); end
                       else if (sr_v >= WIN) begin m_win = 1'b1; enter(4); end
                       else enter(1);
                   end else if (tk) m_ticks++;
                default: begin
                    if (edge_s) begin sc = 1; m_dir = 1'b1; enter(1); end
`ifdef MATCH_AUTO_RESTART_EN
                    else if (expired) begin sc = 1; enter(0); end
                    else if (tk) m_ticks++;
`endif
                end
            endcase
            if (pl && sl_v < 15) sl_v++;
            if (pr && sr_v < 15) sr_v++;
            if (sc) begin sl_v = 0; sr_v = 0; end
        end
        s      = '0;
        s.st   = 3'(m_mode);
        s.en   = (m_mode == 2);
        s.rs   = (m_mode != 2);
        s.dir  = m_dir;
        s.pl   = pl; s.pr = pr; s.sc = sc;
        s.hits = 8'(m_hits);
        s.lvl  = 2'(m_lvl);
        s.go   = (m_mode == 4);
        s.win  = m_win;
        s = mask(s);
        if (s != m_prev || pl || pr || sc) begin
            e.stamp = cyc + 1;
            e.s     = s;
            exp_q.push_back(e);
        end
        m_prev = s;
    endtask

    task automatic cycle(bit r, bit st, bit hl, bit hr, bit ml, bit mr, bit tk);
        @(negedge clk);
        reset           = r;
        bus.start_btn   = st;
        bus.hit_left    = hl;
        bus.hit_right   = hr;
        bus.miss_left   = ml;
        bus.miss_right  = mr;
        bus.tick        = tk;
        bus.score_left  = SW'(sl_v);
        bus.score_right = SW'(sr_v);
        model_step(r, st, hl, hr, ml, mr, tk);
    endtask

    task automatic step(bit r, bit hl, bit hr, bit ml, bit mr);
        cycle(r, start_lvl, hl, hr, ml, mr, 1'b1);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic check(string name, int got, int req);
        total++;
        if (got != req) begin
            bad++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    task automatic wait_mode(int mode, int budget);
        int n = 0;
        while (m_mode != mode && n < budget) begin
            step(0, 0, 0, 0, 0);
            n++;
        end
        if (m_mode != mode) begin
            total++;
            bad++;
            $display("FAIL wait_mode got=%0d required=%0d", m_mode, mode);
        end
    endtask

    // Monitor: every visible change or pulse on the outputs must match the queue head.
    initial begin
        snap_t prev, cur;
        exp_t  e;
        prev = reset_snap();
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            cur = dut_snap();
            if (cur !== prev || cur.pl === 1'b1 || cur.pr === 1'b1 || cur.sc === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event cyc=%0d got=%h required=none", cyc, cur);
                end else begin
                    e = exp_q.pop_front();
                    if (e.stamp != cyc || e.s !== cur) begin
                        bad++;
                        $display("FAIL event got=%h@%0d required=%h@%0d",
                                 cur, cyc, e.s, e.stamp);
                    end
                end
            end
            prev = cur;
        end
    end

    initial begin
        bit r, hl, hr, ml, mr, tk;
        m_prev          = reset_snap();
        bus.tick        = 1'b0;
        bus.start_btn   = 1'b0;
        bus.hit_left    = 1'b0;
        bus.hit_right   = 1'b0;
        bus.miss_left   = 1'b0;
        bus.miss_right  = 1'b0;
        bus.score_left  = '0;
        bus.score_right = '0;

        step(1, 0, 0, 0, 0);
        settle();
        check("reset_state", int'(bus.state), 0);
        check("reset_ball_reset", int'(bus.ball_reset), 1);
        check("reset_serve_dir", int'(bus.serve_dir), 1);
        check("reset_ball_enable", int'(bus.ball_enable), 0);
        check("reset_rally_hits", int'(bus.rally_hits), 0);
        check("reset_game_over", int'(bus.game_over), 0);

        start_lvl = 1'b1;
        step(0, 0, 0, 0, 0);
        settle();
        check("start_state", int'(bus.state), 1);
        check("start_score_clear", int'(bus.score_clear), 1);
        repeat (3) step(0, 0, 0, 0, 0);
        settle();
        check("serve_to_rally", int'(bus.state), 2);
        check("rally_ball_enable", int'(bus.ball_enable), 1);

        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        settle();
        check("rally_hits5", int'(bus.rally_hits), 5);
        check("speed_level2", int'(bus.speed_level), 2);

        step(0, 0, 0, 0, 1);
        settle();
        check("miss_r_point_left", int'(bus.point_left), 1);
        check("miss_r_serve_dir", int'(bus.serve_dir), 1);
        check("miss_r_state", int'(bus.state), 3);
        step(0, 0, 0, 0, 0);
        settle();
        check("point_left_one_cycle", int'(bus.point_left), 0);
        repeat (2) begin
            step(0, 0, 0, 0, 0);
            settle();
        end
        check("hold_to_serve", int'(bus.state), 1);

        wait_mode(2, 20);
        step(0, 0, 0, 1, 1);
        settle();
        check("dbl_miss_pl", int'(bus.point_left), 0);
        check("dbl_miss_pr", int'(bus.point_right), 0);
        check("dbl_miss_dir", int'(bus.serve_dir), 0);
        check("dbl_miss_state", int'(bus.state), 3);

        repeat (2) begin
            wait_mode(2, 20);
            step(0, 0, 0, 0, 1);
        end
        wait_mode(4, 20);
        settle();
        check("game_over_state", int'(bus.state), 4);
        check("game_over_flag", int'(bus.game_over), 1);
        check("winner_left", int'(bus.winner), 0);

        start_lvl = 1'b0;
        step(0, 0, 0, 0, 0);
        start_lvl = 1'b1;
        step(0, 0, 0, 0, 0);
        settle();
        check("restart_score_clear", int'(bus.score_clear), 1);
        check("restart_state", int'(bus.state), 1);

        wait_mode(2, 20);
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        settle();
        check("rst_rally_state", int'(bus.state), 0);
        check("rst_rally_ball_reset", int'(bus.ball_reset), 1);
        check("rst_rally_hits", int'(bus.rally_hits), 0);

        for (int i = 0; i < 4000; i++) begin
            r  = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 19) == 0) start_lvl = ~start_lvl;
            hl = ($urandom_range(0, 2) == 0);
            hr = ($urandom_range(0, 2) == 0);
            ml = ($urandom_range(0, 15) == 0);
            mr = ($urandom_range(0, 15) == 0);
            tk = ($urandom_range(0, 5) != 0);
            cycle(r, start_lvl, hl, hr, ml, mr, tk);
        end

        repeat (4) step(0, 0, 0, 0, 0);
        settle();
        check("leftover_expected_events", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
